// File: rtl/spectrum_bar_builder.sv
// spectrum_bar_builder: reduces a per-bin FFT magnitude stream to BAR_COUNT
// display bars (group maximum -> height scaling -> peak hold with slow decay).
// Bar heights live in an internal register file read through a registered port.
// Optional build macro LOG_SCALE_EN: height = leading-one position + 1 (saturated)
// instead of the default linear top-bits scaling.
module spectrum_bar_builder #(
    parameter int WORD_SIZE       = 16,
    parameter int BIN_COUNT       = 256,
    parameter int BAR_COUNT       = 32,
    parameter int BAR_HEIGHT_BITS = 6,
    parameter int DECAY_PERIOD    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mgValid,
    input  logic                         mgFirst,
    input  logic [WORD_SIZE-1:0]         mg,
    output logic                         mgReady,
    input  logic [$clog2(BAR_COUNT)-1:0] barAddr,
    output logic [BAR_HEIGHT_BITS-1:0]   barData,
    output logic                         frameDone
);

    localparam int BIN_W = $clog2(BIN_COUNT);
    localparam int BAR_W = $clog2(BAR_COUNT);
    localparam int GROUP = BIN_COUNT / BAR_COUNT;
    localparam int GSH   = $clog2(GROUP);
    localparam int DEC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int HMAX  = (2 ** BAR_HEIGHT_BITS) - 1;

    localparam logic [BIN_W-1:0] GMASK    = BIN_W'(GROUP - 1);
    localparam logic [BAR_W-1:0] LAST_BAR = BAR_W'(BAR_COUNT - 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    // Bar height from a group maximum (linear top bits, or log2-style).
    function automatic logic [BAR_HEIGHT_BITS-1:0] height_of(input logic [WORD_SIZE-1:0] gm);
`ifdef LOG_SCALE_EN
        int pos;
        pos = 0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (gm[i]) begin
                pos = i + 1;
            end else begin
                pos = pos;
            end
        end
        if (pos > HMAX) begin
            return BAR_HEIGHT_BITS'(HMAX);
        end else begin
            return BAR_HEIGHT_BITS'(pos);
        end
`else
        return gm[WORD_SIZE-1 -: BAR_HEIGHT_BITS];
`endif
    endfunction

    state_t                       state_r, state_s;
    logic [BIN_W-1:0]             bin_r, bin_s;
    logic [WORD_SIZE-1:0]         group_max_r, group_max_s;
    logic [DEC_W-1:0]             decay_cnt_r, decay_cnt_s;
    logic                         ready_r;
    logic                         frame_done_r, frame_done_s;
    logic [BAR_HEIGHT_BITS-1:0]   held_r [BAR_COUNT];
    logic [BAR_HEIGHT_BITS-1:0]   bar_data_r;

    logic                         accept_s;
    logic [BIN_W-1:0]             sample_idx_s;
    logic [WORD_SIZE-1:0]         sample_max_s;
    logic                         sample_last_s;
    logic [BIN_W-1:0]             prev_bin_s;
    logic [BAR_W-1:0]             upd_bar_s;
    logic [BAR_HEIGHT_BITS-1:0]   h_s;
    logic [BAR_HEIGHT_BITS-1:0]   held_cur_s;
    logic [BAR_HEIGHT_BITS-1:0]   new_held_s;
    logic                         decay_tick_s;
    logic                         held_we_s;

    assign mgReady   = ready_r;
    assign barData   = bar_data_r;
    assign frameDone = frame_done_r;

    // Per-sample datapath: bin index, running maximum and end-of-group detect.
    always_comb begin
        accept_s     = mgValid && ready_r;
        sample_idx_s = mgFirst ? {BIN_W{1'b0}} : bin_r;
        if (mgFirst) begin
            sample_max_s = mg;
        end else if (mg > group_max_r) begin
            sample_max_s = mg;
        end else begin
            sample_max_s = group_max_r;
        end
        sample_last_s = ((sample_idx_s & GMASK) == GMASK);
    end

    // Bar update datapath: bar index of the group just closed and peak-hold result.
    // bin_r already points past the closed group (wrapping to 0 after the last bar).
    always_comb begin
        prev_bin_s   = bin_r - BIN_W'(1);
        upd_bar_s    = BAR_W'(prev_bin_s >> GSH);
        h_s          = height_of(group_max_r);
        decay_tick_s = (decay_cnt_r == DEC_LAST);
        held_cur_s   = held_r[upd_bar_s];
        if (h_s >= held_cur_s) begin
            new_held_s = h_s;
        end else if (decay_tick_s) begin
            new_held_s = held_cur_s - BAR_HEIGHT_BITS'(1);
        end else begin
            new_held_s = held_cur_s;
        end
    end

    // Next-state and control decode for the collect/update FSM.
    always_comb begin
        state_s      = state_r;
        bin_s        = bin_r;
        group_max_s  = group_max_r;
        decay_cnt_s  = decay_cnt_r;
        frame_done_s = 1'b0;
        held_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && mgFirst) begin
                    bin_s       = sample_idx_s + BIN_W'(1);
                    group_max_s = sample_max_s;
                    state_s     = sample_last_s ? UPDATE : COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s) begin
                    bin_s       = sample_idx_s + BIN_W'(1);
                    group_max_s = sample_max_s;
                    state_s     = sample_last_s ? UPDATE : COLLECT;
                end else begin
                    state_s = COLLECT;
                end
            end
            UPDATE: begin
                held_we_s   = 1'b1;
                group_max_s = {WORD_SIZE{1'b0}};
                if (upd_bar_s == LAST_BAR) begin
                    frame_done_s = 1'b1;
                    bin_s        = {BIN_W{1'b0}};
                    decay_cnt_s  = decay_tick_s ? {DEC_W{1'b0}} : (decay_cnt_r + DEC_W'(1));
                    state_s      = IDLE;
                end else begin
                    state_s = COLLECT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control and accumulation registers; ready is low in reset and while updating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            bin_r        <= {BIN_W{1'b0}};
            group_max_r  <= {WORD_SIZE{1'b0}};
            decay_cnt_r  <= {DEC_W{1'b0}};
            ready_r      <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            bin_r        <= bin_s;
            group_max_r  <= group_max_s;
            decay_cnt_r  <= decay_cnt_s;
            ready_r      <= (state_s != UPDATE);
            frame_done_r <= frame_done_s;
        end
    end

    // Held bar register file, written once per closed group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BAR_COUNT; i++) begin
                held_r[i] <= {BAR_HEIGHT_BITS{1'b0}};
            end
        end else if (held_we_s) begin
            held_r[upd_bar_s] <= new_held_s;
        end
    end

    // Registered display read port; a same-cycle write returns the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_data_r <= {BAR_HEIGHT_BITS{1'b0}};
        end else begin
            bar_data_r <= held_r[barAddr];
        end
    end

endmodule

// File: tb/tb_spectrum_bar_builder.sv
// Self-checking bench for spectrum_bar_builder (default parameters).
module tb_spectrum_bar_builder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mgValid = 1'b0;
    logic        mgFirst = 1'b0;
    logic [15:0] mg = 16'h0000;
    logic        mgReady;
    logic [4:0]  barAddr = 5'd0;
    logic [5:0]  barData;
    logic        frameDone;

    int checks = 0;
    int errors = 0;

    // free-running event counters sampled mid-cycle
    int fd_cnt = 0;
    int stall_cnt = 0;
    int xfer_cnt = 0;

    logic [15:0] frame_mem [256];

    typedef struct {
        int          bin;
        logic [15:0] val;
        int          bar;
        logic [5:0]  exp_lin;
        logic [5:0]  exp_log;
    } vec_t;

    vec_t vecs [7];

    spectrum_bar_builder dut (
        .clk       (clk),
        .reset     (reset),
        .mgValid   (mgValid),
        .mgFirst   (mgFirst),
        .mg        (mg),
        .mgReady   (mgReady),
        .barAddr   (barAddr),
        .barData   (barData),
        .frameDone (frameDone)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (frameDone) fd_cnt++;
            if (!mgReady) stall_cnt++;
            if (mgValid && mgReady) xfer_cnt++;
        end
    end

    function automatic logic [5:0] pick(input logic [5:0] lin, input logic [5:0] lg);
`ifdef LOG_SCALE_EN
        return lg;
`else
        return lin;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mgValid = 1'b0; mgFirst = 1'b0; mg = 16'h0000;
        repeat (2) @(negedge clk);
        check("ready_in_reset", {31'd0, mgReady}, 32'd0);
        check("framedone_in_reset", {31'd0, frameDone}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, mgReady}, 32'd1);
    endtask

    // drive one sample and hold it until the block takes it
    task automatic send(input logic [15:0] v, input logic f);
        int guard;
        guard = 0;
        @(negedge clk);
        mgValid = 1'b1; mg = v; mgFirst = f;
        while (!mgReady && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!mgReady) check("ready_timeout", {31'd0, mgReady}, 32'd1);
    endtask

    task automatic idle_wait(input int n);
        @(negedge clk);
        mgValid = 1'b0; mgFirst = 1'b0; mg = 16'h0000;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int nbins);
        for (int i = 0; i < nbins; i++) begin
            send(frame_mem[i], (i == 0) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic clear_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) frame_mem[i] = v;
    endtask

    task automatic read_bar(input int a, output logic [5:0] d);
        @(negedge clk);
        barAddr = 5'(a);
        @(negedge clk);
        d = barData;
    endtask

    initial begin
        logic [5:0] d;
        int base_fd, base_stall, base_xfer;
        int nb;

        vecs[0] = '{bin: 1,   val: 16'h8000, bar: 0,  exp_lin: 6'd32, exp_log: 6'd16};
        vecs[1] = '{bin: 255, val: 16'hFFFF, bar: 31, exp_lin: 6'd63, exp_log: 6'd16};
        vecs[2] = '{bin: 8,   val: 16'h03FF, bar: 1,  exp_lin: 6'd0,  exp_log: 6'd10};
        vecs[3] = '{bin: 100, val: 16'h0400, bar: 12, exp_lin: 6'd1,  exp_log: 6'd11};
        vecs[4] = '{bin: 7,   val: 16'hFC00, bar: 0,  exp_lin: 6'd63, exp_log: 6'd16};
        vecs[5] = '{bin: 200, val: 16'h7FFF, bar: 25, exp_lin: 6'd31, exp_log: 6'd15};
        vecs[6] = '{bin: 130, val: 16'h0100, bar: 16, exp_lin: 6'd0,  exp_log: 6'd9};

        // reset state: every bar reads 0, no frameDone
        do_reset();
        base_fd = fd_cnt;
        for (int a = 0; a < 32; a++) begin
            read_bar(a, d);
            check("reset_bar", {26'd0, d}, 32'd0);
        end
        check("reset_no_framedone", fd_cnt - base_fd, 32'd0);

        // basic frame: max of bar0 is 0x8000, one frameDone, 32 stall cycles
        clear_mem(16'h0000);
        frame_mem[0] = 16'h1000; frame_mem[1] = 16'h8000; frame_mem[2] = 16'h0400;
        base_fd = fd_cnt; base_stall = stall_cnt;
        send_frame(256);
        idle_wait(4);
        check("basic_framedone", fd_cnt - base_fd, 32'd1);
        check("basic_stalls", stall_cnt - base_stall, 32'd32);
        read_bar(0, d);
        check("basic_bar0", {26'd0, d}, {26'd0, pick(6'd32, 6'd16)});
        read_bar(1, d);
        check("basic_bar1", {26'd0, d}, 32'd0);

        // table: one non-zero bin per frame from reset
        for (int v = 0; v < 7; v++) begin
            do_reset();
            clear_mem(16'h0000);
            frame_mem[vecs[v].bin] = vecs[v].val;
            send_frame(256);
            idle_wait(4);
            read_bar(vecs[v].bar, d);
            check("vec_bar", {26'd0, d}, {26'd0, pick(vecs[v].exp_lin, vecs[v].exp_log)});
            nb = (vecs[v].bar + 1) % 32;
            read_bar(nb, d);
            check("vec_neighbour", {26'd0, d}, 32'd0);
        end

        // peak hold and decay: decay tick on the frame whose counter is 3
        do_reset();
        clear_mem(16'h0000);
        frame_mem[0] = 16'hFC00;
        send_frame(256);
        idle_wait(4);
        read_bar(0, d);
        check("decay_f0", {26'd0, d}, {26'd0, pick(6'd63, 6'd16)});
        clear_mem(16'h0000);
        for (int f = 1; f <= 4; f++) begin
            send_frame(256);
            idle_wait(4);
            read_bar(0, d);
            if (f < 3) check("decay_hold", {26'd0, d}, {26'd0, pick(6'd63, 6'd16)});
            else       check("decay_step", {26'd0, d}, {26'd0, pick(6'd62, 6'd15)});
        end

        // restart on mgFirst at bin 100: bars 0-11 kept, partial bar12 dropped
        do_reset();
        clear_mem(16'h4000);
        for (int i = 96; i < 100; i++) frame_mem[i] = 16'hF000;
        base_fd = fd_cnt;
        send_frame(100);
        idle_wait(4);
        check("restart_no_framedone", fd_cnt - base_fd, 32'd0);
        clear_mem(16'h0000);
        send_frame(256);
        idle_wait(4);
        check("restart_framedone", fd_cnt - base_fd, 32'd1);
        read_bar(0, d);
        check("restart_bar0", {26'd0, d}, {26'd0, pick(6'd16, 6'd15)});
        read_bar(11, d);
        check("restart_bar11", {26'd0, d}, {26'd0, pick(6'd16, 6'd15)});
        read_bar(12, d);
        check("restart_bar12", {26'd0, d}, 32'd0);
        read_bar(13, d);
        check("restart_bar13", {26'd0, d}, 32'd0);

        // IDLE discards and stall conservation: bin i carries i<<8
        do_reset();
        base_xfer = xfer_cnt; base_fd = fd_cnt;
        for (int i = 0; i < 5; i++) send(16'hFFFF, 1'b0);
        for (int i = 0; i < 256; i++) frame_mem[i] = 16'(i << 8);
        send_frame(256);
        idle_wait(4);
        check("cons_xfers", xfer_cnt - base_xfer, 32'd261);
        check("cons_framedone", fd_cnt - base_fd, 32'd1);
        read_bar(0, d);
        check("cons_bar0", {26'd0, d}, {26'd0, pick(6'd1, 6'd11)});
        read_bar(15, d);
        check("cons_bar15", {26'd0, d}, {26'd0, pick(6'd31, 6'd15)});
        read_bar(31, d);
        check("cons_bar31", {26'd0, d}, {26'd0, pick(6'd63, 6'd16)});

        // reset mid-frame wipes every bar
        clear_mem(16'hFFFF);
        send_frame(51);
        do_reset();
        base_fd = fd_cnt;
        for (int a = 0; a < 32; a += 5) begin
            read_bar(a, d);
            check("midreset_bar", {26'd0, d}, 32'd0);
        end
        idle_wait(3);
        check("midreset_no_framedone", fd_cnt - base_fd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
